// File: rtl/pe_pkg.sv
// Shared widths, FSM state encoding and weight decode helper for the
// log-weight MAC controller and the external bit-shifter PE.
package pe_pkg;

    localparam int W_WT   = 4;
    localparam int W_ACT  = 8;
    localparam int W_PROD = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } pe_state_t;

    // Shift code 0 means "zero weight" whatever the sign bit says.
    function automatic logic wt_is_zero(input logic [W_WT-1:0] wt);
        return wt[W_WT-2:0] == '0;
    endfunction

endpackage

// File: rtl/pe_mac_ctrl.sv
// Dot-product controller: streams (weight, activation) pairs to an external
// bit-shifter PE, skips zero weights and accumulates the returned products.
module pe_mac_ctrl
    import pe_pkg::*;
#(
    parameter int N     = 9,
    parameter int ACC_W = 24,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_WT-1:0]   i_weight,
    input  logic [W_ACT-1:0]  i_activation,
    output logic              o_pe_skip,
    output logic [W_WT-1:0]   o_pe_weight,
    output logic [W_ACT-1:0]  o_pe_activation,
    input  logic [W_PROD-1:0] i_pe_product,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ACC_W-1:0]  o_sum,
    output logic [CNT_W-1:0]  o_skip_cnt,
    output logic              o_busy
);

    pe_state_t         state;
    logic [CNT_W-1:0]  pair_cnt;
    logic [CNT_W-1:0]  skip_cnt;
    logic [ACC_W-1:0]  acc;
    logic              pend;
    logic              ready_q;
    logic              valid_q;
    logic              busy_q;

    logic              xfer;
    logic              wt_zero;
    logic              issue;
    logic              last_pair;
    logic [ACC_W-1:0]  prod_ext;

    // ready_q is only ever high in RUN, so it doubles as the state qualifier.
    assign xfer      = ready_q & i_valid;
    assign wt_zero   = wt_is_zero(i_weight);
    assign issue     = xfer & ~wt_zero;
    assign last_pair = xfer && (pair_cnt == CNT_W'(N - 1));
    assign prod_ext  = {{(ACC_W - W_PROD){i_pe_product[W_PROD-1]}}, i_pe_product};

    // NOTE: every output gets its idle value first so no path leaves one unassigned (no latch).
    always_comb begin
        o_pe_skip       = 1'b1;
        o_pe_weight     = '0;
        o_pe_activation = '0;
        if (issue) begin
            o_pe_skip       = 1'b0;
            o_pe_weight     = i_weight;
            o_pe_activation = i_activation;
        end
    end

    // NOTE: all state is updated with <= so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            acc      <= '0;
            pair_cnt <= '0;
            skip_cnt <= '0;
            pend     <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (i_clear) begin
            state    <= ST_IDLE;
            acc      <= '0;
            pair_cnt <= '0;
            skip_cnt <= '0;
            pend     <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Product of the pair issued last cycle arrives now.
            pend <= issue;
            if (pend) begin
                acc <= acc + prod_ext;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state    <= ST_RUN;
                        acc      <= '0;
                        pair_cnt <= '0;
                        skip_cnt <= '0;
                        ready_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        pair_cnt <= pair_cnt + CNT_W'(1);
                        if (wt_zero) begin
                            skip_cnt <= skip_cnt + CNT_W'(1);
                        end
                        if (last_pair) begin
                            state   <= ST_DRAIN;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    state   <= ST_DONE;
                    valid_q <= 1'b1;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_sum      = acc;
    assign o_skip_cnt = skip_cnt;

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Directed + randomized bench for pe_mac_ctrl with a behavioural PE and
// a dot-product reference model computed from the log-weight rules.
module tb_pe_mac_ctrl;
    import pe_pkg::*;

    localparam int N     = 9;
    localparam int ACC_W = 24;
    localparam int CNT_W = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic              i_clear;
    logic              i_valid;
    logic              o_ready;
    logic [W_WT-1:0]   i_weight;
    logic [W_ACT-1:0]  i_activation;
    logic              o_pe_skip;
    logic [W_WT-1:0]   o_pe_weight;
    logic [W_ACT-1:0]  o_pe_activation;
    logic [W_PROD-1:0] i_pe_product;
    logic              o_valid;
    logic              i_ready;
    logic [ACC_W-1:0]  o_sum;
    logic [CNT_W-1:0]  o_skip_cnt;
    logic              o_busy;

    int tests = 0;
    int fails = 0;

    logic [W_WT-1:0]  wt  [N];
    logic [W_ACT-1:0] act [N];

    pe_mac_ctrl #(.N(N), .ACC_W(ACC_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_clear        (i_clear),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_weight       (i_weight),
        .i_activation   (i_activation),
        .o_pe_skip      (o_pe_skip),
        .o_pe_weight    (o_pe_weight),
        .o_pe_activation(o_pe_activation),
        .i_pe_product   (i_pe_product),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_sum          (o_sum),
        .o_skip_cnt     (o_skip_cnt),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    // Log weight: code k>0 scales the activation by 2^(k-1), bit 3 negates.
    function automatic longint pe_val(input logic [3:0] w, input logic [7:0] a);
        longint m;
        if (w[2:0] == 3'd0) return 0;
        m = longint'(a) << (int'(w[2:0]) - 1);
        return w[3] ? -m : m;
    endfunction

    // External PE with one cycle of latency; junk on idle cycles must never be summed.
    always @(posedge clk) begin
        if (o_pe_skip) i_pe_product <= W_PROD'($urandom);
        else           i_pe_product <= W_PROD'(pe_val(o_pe_weight, o_pe_activation));
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_ready", o_ready, 1);
        check("start_valid", o_valid, 0);
        check("start_skip_clr", o_skip_cnt, 0);
        check("start_sum_clr", $signed(o_sum), 0);
    endtask

    // Presents pairs with random gaps; i_start is toggled to show it is ignored in RUN.
    task automatic stream(input int gap_pct, input int n_pairs);
        int k = 0;
        int guard = 0;
        bit go;
        bit taken;
        while (k < n_pairs && guard < 500) begin
            go           = ($urandom_range(99) >= gap_pct);
            i_valid      = go;
            i_weight     = go ? wt[k]  : 4'($urandom);
            i_activation = go ? act[k] : 8'($urandom);
            i_start      = 1'($urandom_range(1));
            #1;
            taken = go && o_ready;
            if (taken) begin
                check("pe_skip", o_pe_skip, wt[k][2:0] == 3'd0);
                if (wt[k][2:0] != 3'd0) begin
                    check("pe_weight", o_pe_weight, wt[k]);
                    check("pe_act", o_pe_activation, act[k]);
                end
            end else begin
                check("pe_skip_idle", o_pe_skip, 1);
            end
            step();
            if (taken) k++;
            guard++;
        end
        check("stream_accepts", k, n_pairs);
        i_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic run_job(input int gap_pct, input int stall);
        longint es = 0;
        longint ek = 0;
        for (int i = 0; i < N; i++) begin
            es += pe_val(wt[i], act[i]);
            if (wt[i][2:0] == 3'd0) ek++;
        end
        start_job();
        stream(gap_pct, N);
        check("drain_valid", o_valid, 0);
        check("drain_ready", o_ready, 0);
        check("drain_busy", o_busy, 1);
        step();
        check("latency_valid", o_valid, 1);
        for (int s = 0; s < stall; s++) begin
            i_start = 1'($urandom_range(1));
            check("stall_valid", o_valid, 1);
            check("stall_sum", $signed(o_sum), es);
            step();
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        check("done_valid", o_valid, 1);
        check("sum", $signed(o_sum), es);
        check("skip_cnt", o_skip_cnt, ek);
        step();
        i_ready = 1'b0;
        check("idle_valid", o_valid, 0);
        check("idle_busy", o_busy, 0);
        check("skip_hold", o_skip_cnt, ek);
        step();
        check("skip_hold2", o_skip_cnt, ek);
    endtask

    task automatic abort_job(input bit use_rst);
        int vseen = 0;
        int rseen = 0;
        start_job();
        stream(30, 4);
        if (use_rst) begin
            rst = 1'b0;
            #1;
            check("rst_ready", o_ready, 0);
            check("rst_valid", o_valid, 0);
            check("rst_busy", o_busy, 0);
            check("rst_pe_skip", o_pe_skip, 1);
            step();
            rst = 1'b1;
        end else begin
            i_clear = 1'b1;
            step();
            i_clear = 1'b0;
        end
        check("abort_busy", o_busy, 0);
        check("abort_sum", $signed(o_sum), 0);
        check("abort_skip", o_skip_cnt, 0);
        for (int c = 0; c < 8; c++) begin
            i_valid = 1'($urandom_range(1));
            i_ready = 1'($urandom_range(1));
            step();
            if (o_valid) vseen++;
            if (o_ready || o_busy) rseen++;
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("abort_no_valid", vseen, 0);
        check("abort_waits_start", rseen, 0);
    endtask

    task automatic fill_random(input int zero_pct);
        for (int i = 0; i < N; i++) begin
            wt[i]  = 4'($urandom);
            act[i] = 8'($urandom);
            if ($urandom_range(99) < zero_pct) wt[i][2:0] = 3'd0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        i_start      = 1'b0;
        i_clear      = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_weight     = '0;
        i_activation = '0;
        step();
        i_start = 1'b1;
        i_valid = 1'b1;
        i_weight = 4'b0011;
        step();
        check("reset_ready", o_ready, 0);
        check("reset_valid", o_valid, 0);
        check("reset_busy", o_busy, 0);
        check("reset_pe_skip", o_pe_skip, 1);
        check("reset_pe_weight", o_pe_weight, 0);
        check("reset_pe_act", o_pe_activation, 0);
        check("reset_sum", $signed(o_sum), 0);
        check("reset_skip_cnt", o_skip_cnt, 0);
        i_start = 1'b0;
        i_valid = 1'b0;
        rst = 1'b1;
        step();
        check("post_reset_idle", o_busy, 0);

        // Start and clear together in IDLE: clear wins.
        i_start = 1'b1;
        i_clear = 1'b1;
        step();
        i_start = 1'b0;
        i_clear = 1'b0;
        check("start_clear_busy", o_busy, 0);
        check("start_clear_ready", o_ready, 0);

        for (int i = 0; i < N; i++) begin wt[i] = 4'b0001; act[i] = 8'd10;  end
        run_job(0, 0);
        for (int i = 0; i < N; i++) begin wt[i] = 4'b1111; act[i] = 8'd255; end
        run_job(0, 1);
        for (int i = 0; i < N; i++) begin wt[i] = (i % 2 == 0) ? 4'b0000 : 4'b1000; act[i] = 8'd200; end
        run_job(0, 0);

        fill_random(20);
        run_job(40, 5);

        fill_random(20);
        abort_job(1'b0);
        run_job(30, 2);

        fill_random(20);
        abort_job(1'b1);
        run_job(30, 3);

        for (int j = 0; j < 4; j++) begin
            fill_random(25);
            run_job(50, j);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_mac_ctrl.md
PE_MAC_CTRL -- requirements
Module: pe_mac_ctrl

Interface
REQ-001 Parameter N, default 9: number of (weight, activation) pairs per dot product; legal range 2..256.
REQ-002 Parameter ACC_W, default 24: accumulator width; SHALL satisfy ACC_W >= 15 + clog2(N).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  request a new dot product; sampled only in IDLE.
REQ-006 i_clear  input  1  synchronous abort to IDLE; no result is produced.
REQ-007 i_valid / o_ready  input / output  1 / 1  pair-stream handshake; transfer when both are high.
REQ-008 i_weight  input  4  sign-magnitude log weight; bit 3 is the sign, bits 2:0 are the shift code.
REQ-009 i_activation  input  8  unsigned activation.
REQ-010 o_pe_skip / o_pe_weight / o_pe_activation  output  1 / 4 / 8  drive to the external bit-shifter PE.
REQ-011 i_pe_product  input  15  signed PE result, valid one cycle after issue.
REQ-012 o_valid / i_ready  output / input  1 / 1  result handshake.
REQ-013 o_sum  output  ACC_W  signed dot-product result.
REQ-014 o_skip_cnt  output  clog2(N+1)  pairs skipped in the current or last job.
REQ-015 o_busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: o_ready=0, o_valid=0; on i_start, clear acc, pair count and skip count, then go to RUN.
REQ-018 RUN: o_ready=1; each accepted pair increments the pair count.
REQ-019 RUN: an accepted pair with weight[2:0]!=0 is issued: o_pe_skip=0, o_pe_weight and o_pe_activation driven combinationally from the inputs, pend flag set for the next cycle.
REQ-020 An accepted pair with weight[2:0]==0 (both 4'b0000 and 4'b1000) is not issued: o_pe_skip=1, o_skip_cnt increments, no accumulation.
REQ-021 No transfer in a cycle (i_valid=0, or state is not RUN): o_pe_skip=1 and pend=0 for the next cycle.
REQ-022 Whenever pend=1, acc <= acc + sign-extend(i_pe_product) to ACC_W bits; no saturation is required per REQ-002.
REQ-023 The transfer that brings the pair count to N moves RUN to DRAIN; o_ready=0 from the next cycle.
REQ-024 DRAIN lasts exactly one cycle, absorbing the last pending product, then moves to DONE.
REQ-025 DONE: o_valid=1 and o_sum=acc; both stay stable until i_ready=1, then go to IDLE.
REQ-026 Latency: last pair accepted at cycle t gives o_valid=1 at cycle t+2.
REQ-027 i_start outside IDLE is ignored.
REQ-028 i_clear has priority over every other event: next state IDLE, acc and counts cleared, pend cleared, o_valid=0.
REQ-029 i_start and i_clear together in IDLE: i_clear wins and the block stays in IDLE.
REQ-030 o_skip_cnt holds its value in IDLE until the next i_start.

Reset
REQ-031 While rst=0: state=IDLE, acc=0, pair count=0, o_skip_cnt=0, pend=0.
REQ-032 While rst=0: o_ready=0, o_valid=0, o_busy=0, o_pe_skip=1, o_pe_weight=0, o_pe_activation=0.
REQ-033 rst asserted mid-RUN or mid-DONE discards the job; after release the block waits for a fresh i_start.

Structure
REQ-034 Shared package pe_pkg holds: W_WT=4, W_ACT=8, W_PROD=15, the state enum and a weight-is-zero helper function.
REQ-035 No sub-module: the bit-shifter PE stays external, connected through the o_pe_* and i_pe_product ports.

Verification
REQ-036 N=9; all weights 4'b0001, all activations 10, no gaps -> o_sum=90, o_skip_cnt=0, o_valid two cycles after the 9th accept.
REQ-037 N=9; weight 4'b1111 with activation 255 on all pairs -> o_sum=-146880.
REQ-038 N=9; weights alternating 4'b0000 and 4'b1000, activation 200 -> o_pe_skip high throughout, o_sum=0, o_skip_cnt=9.
REQ-039 Random i_valid gaps plus i_ready held low 5 cycles in DONE -> o_sum stable and o_valid held for the full stall; result matches the software model.
REQ-040 i_clear, or rst low, after 4 accepts -> IDLE with o_valid never asserted; the next job gives a correct independent sum.
